// File: rtl/fc1_kr_csr_bridge.sv
// Host-to-channel CSR bridge: decodes a channel from the host address, strobes that
// channel's CSR port and returns read data, or an error on timeout/bad channel.
module fc1_kr_csr_bridge #(
  parameter int unsigned CHANNELS     = 1,
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [63:0] TIMEOUT_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                   iCLK_CORE,
  input  logic                   iRST_CORE_N,
  input  logic                   iHOST_WR_EN,
  input  logic                   iHOST_RD_EN,
  input  logic [21:0]            iHOST_ADDR,
  input  logic [63:0]            iHOST_WR_DATA,
  output logic                   oHOST_BUSY,
  output logic [63:0]            oHOST_RD_DATA,
  output logic                   oHOST_RD_DATA_V,
  output logic                   oHOST_RD_ERR,
  output logic [CHANNELS-1:0]    oCSR_WR_EN,
  output logic [CHANNELS-1:0]    oCSR_RD_EN,
  output logic [CHANNELS*14-1:0] oCSR_ADDR,
  output logic [CHANNELS*64-1:0] oCSR_WR_DATA,
  input  logic [CHANNELS*64-1:0] iCSR_RD_DATA,
  input  logic [CHANNELS-1:0]    iCSR_RD_DATA_V,
  output logic [15:0]            oTIMEOUT_CNT
);

  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StRdWait, StResp} state_e;

  state_e                state_q;
  logic [7:0]            ch_q;
  logic                  ch_ok_q;
  logic                  is_rd_q;
  logic [13:0]           addr_q;
  logic [63:0]           wdata_q;
  logic [15:0]           wait_cnt_q;
  logic [15:0]           timeout_cnt_q;
  logic                  busy_q;
  logic [63:0]           rd_data_q;
  logic                  rd_v_q;
  logic                  rd_err_q;
  logic [CHANNELS-1:0]   wr_en_q;
  logic [CHANNELS-1:0]   rd_en_q;

  logic [7:0]            host_ch;
  logic                  host_ok;
  logic [CHANNELS-1:0]   host_sel;
  logic                  sel_v;
  logic [63:0]           sel_data;

  assign host_ch = iHOST_ADDR[21:14];
  assign host_ok = 32'(host_ch) < CHANNELS;

  // Out-of-range channels decode to an all-zero select, so they never strobe.
  always_comb begin
    host_sel = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      host_sel[i] = (32'(host_ch) == i);
    end
  end

  always_comb begin
    sel_v    = 1'b0;
    sel_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (32'(ch_q) == i) begin
        sel_v    = iCSR_RD_DATA_V[i];
        sel_data = iCSR_RD_DATA[i*64 +: 64];
      end
    end
  end

  always_ff @(posedge iCLK_CORE or negedge iRST_CORE_N) begin
    if (!iRST_CORE_N) begin
      state_q       <= StIdle;
      ch_q          <= '0;
      ch_ok_q       <= 1'b0;
      is_rd_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wait_cnt_q    <= '0;
      timeout_cnt_q <= '0;
      busy_q        <= 1'b0;
      rd_data_q     <= '0;
      rd_v_q        <= 1'b0;
      rd_err_q      <= 1'b0;
      wr_en_q       <= '0;
      rd_en_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Read has priority; a simultaneous write is dropped.
          if (iHOST_RD_EN || iHOST_WR_EN) begin
            state_q <= StIssue;
            busy_q  <= 1'b1;
            ch_q    <= host_ch;
            ch_ok_q <= host_ok;
            is_rd_q <= iHOST_RD_EN;
            addr_q  <= iHOST_ADDR[13:0];
            if (iHOST_RD_EN) begin
              rd_en_q <= host_sel;
            end else begin
              wr_en_q <= host_sel;
              wdata_q <= iHOST_WR_DATA;
            end
          end
        end
        StIssue: begin
          wr_en_q <= '0;
          rd_en_q <= '0;
          if (!is_rd_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (ch_ok_q) begin
            state_q    <= StRdWait;
            wait_cnt_q <= '0;
          end else begin
            state_q   <= StResp;
            rd_v_q    <= 1'b1;
            rd_err_q  <= 1'b1;
            rd_data_q <= TIMEOUT_DATA;
          end
        end
        StRdWait: begin
          if (sel_v) begin
            state_q   <= StResp;
            rd_v_q    <= 1'b1;
            rd_err_q  <= 1'b0;
            rd_data_q <= sel_data;
          end else if (wait_cnt_q == WaitLast) begin
            state_q   <= StResp;
            rd_v_q    <= 1'b1;
            rd_err_q  <= 1'b1;
            rd_data_q <= TIMEOUT_DATA;
            if (timeout_cnt_q != 16'hFFFF) timeout_cnt_q <= timeout_cnt_q + 16'd1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        StResp: begin
          state_q  <= StIdle;
          busy_q   <= 1'b0;
          rd_v_q   <= 1'b0;
          rd_err_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign oHOST_BUSY      = busy_q;
  assign oHOST_RD_DATA   = rd_data_q;
  assign oHOST_RD_DATA_V = rd_v_q;
  assign oHOST_RD_ERR    = rd_err_q;
  assign oCSR_WR_EN      = wr_en_q;
  assign oCSR_RD_EN      = rd_en_q;
  assign oCSR_ADDR       = {CHANNELS{addr_q}};
  assign oCSR_WR_DATA    = {CHANNELS{wdata_q}};
  assign oTIMEOUT_CNT    = timeout_cnt_q;

endmodule

// File: tb/tb_fc1_kr_csr_bridge.sv
// Directed bench for fc1_kr_csr_bridge with 4 channels and an 8-cycle read timeout.
module tb_fc1_kr_csr_bridge;

  localparam int unsigned Ch     = 4;
  localparam logic [63:0] ToData = 64'hDEAD_BEEF_DEAD_BEEF;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wr_en, rd_en;
  logic [21:0]    addr;
  logic [63:0]    wdata;
  logic           busy;
  logic [63:0]    rdata;
  logic           rdv, rderr;
  logic [Ch-1:0]  csr_wr, csr_rd;
  logic [Ch*14-1:0] csr_addr;
  logic [Ch*64-1:0] csr_wdata;
  logic [Ch*64-1:0] csr_rdata;
  logic [Ch-1:0]  csr_rdv;
  logic [15:0]    tcnt;

  int n_cmp = 0;
  int n_bad = 0;

  fc1_kr_csr_bridge #(
    .CHANNELS    (Ch),
    .TIMEOUT     (8),
    .TIMEOUT_DATA(ToData)
  ) dut (
    .iCLK_CORE      (clk),
    .iRST_CORE_N    (rst_n),
    .iHOST_WR_EN    (wr_en),
    .iHOST_RD_EN    (rd_en),
    .iHOST_ADDR     (addr),
    .iHOST_WR_DATA  (wdata),
    .oHOST_BUSY     (busy),
    .oHOST_RD_DATA  (rdata),
    .oHOST_RD_DATA_V(rdv),
    .oHOST_RD_ERR   (rderr),
    .oCSR_WR_EN     (csr_wr),
    .oCSR_RD_EN     (csr_rd),
    .oCSR_ADDR      (csr_addr),
    .oCSR_WR_DATA   (csr_wdata),
    .iCSR_RD_DATA   (csr_rdata),
    .iCSR_RD_DATA_V (csr_rdv),
    .oTIMEOUT_CNT   (tcnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    csr_rdata = '0; csr_rdv = '0;
    tick(2);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdv", 64'(rdv), 64'd0);
    chk("rst_err", 64'(rderr), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_strobes", 64'({csr_wr, csr_rd}), 64'd0);
    chk("rst_addr", 64'(csr_addr), 64'd0);
    chk("rst_wdata", csr_wdata[63:0], 64'd0);
    chk("rst_tcnt", 64'(tcnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Write to channel 2
    wr_en = 1'b1; addr = {8'd2, 14'h0010}; wdata = 64'h1234;
    tick();
    wr_en = 1'b0;
    chk("wr_strobe", 64'(csr_wr), 64'h4);
    chk("wr_no_rd", 64'(csr_rd), 64'h0);
    chk("wr_busy", 64'(busy), 64'd1);
    chk("wr_addr_bcast", 64'(csr_addr), 64'({4{14'h0010}}));
    chk("wr_data_ch2", csr_wdata[191:128], 64'h1234);
    chk("wr_data_ch0", csr_wdata[63:0], 64'h1234);
    tick();
    chk("wr_strobe_off", 64'(csr_wr), 64'h0);
    chk("wr_busy_off", 64'(busy), 64'd0);

    // Read channel 1, responds 3 cycles after the strobe; ch0 chatters meanwhile
    rd_en = 1'b1; addr = {8'd1, 14'h0020};
    tick();
    rd_en = 1'b0;
    chk("rd1_strobe", 64'(csr_rd), 64'h2);
    chk("rd1_addr", 64'(csr_addr[41:28]), 64'h20);
    chk("rd1_wdata_kept", csr_wdata[63:0], 64'h1234);
    csr_rdv[0] = 1'b1; csr_rdata[63:0] = 64'hBAD0;
    tick();
    chk("rd1_strobe_off", 64'(csr_rd), 64'h0);
    chk("rd1_wait_a", 64'(rdv), 64'd0);
    csr_rdv = '0;
    tick();
    chk("rd1_wait_b", 64'(rdv), 64'd0);
    tick();
    chk("rd1_wait_c", 64'(rdv), 64'd0);
    csr_rdv[1] = 1'b1; csr_rdata[127:64] = 64'hCAFE;
    tick();
    csr_rdv = '0;
    chk("rd1_v", 64'(rdv), 64'd1);
    chk("rd1_data", rdata, 64'hCAFE);
    chk("rd1_err", 64'(rderr), 64'd0);
    chk("rd1_busy", 64'(busy), 64'd1);
    tick();
    chk("rd1_v_off", 64'(rdv), 64'd0);
    chk("rd1_busy_off", 64'(busy), 64'd0);

    // Read channel 3 which never answers
    rd_en = 1'b1; addr = {8'd3, 14'h0030};
    tick();
    rd_en = 1'b0;
    chk("to_strobe", 64'(csr_rd), 64'h8);
    tick(8);
    chk("to_pre_v", 64'(rdv), 64'd0);
    tick();
    chk("to_v", 64'(rdv), 64'd1);
    chk("to_err", 64'(rderr), 64'd1);
    chk("to_data", rdata, ToData);
    chk("to_cnt", 64'(tcnt), 64'd1);
    csr_rdv[3] = 1'b1; csr_rdata[255:192] = 64'h5555;
    tick();
    chk("to_v_off", 64'(rdv), 64'd0);
    chk("to_busy_off", 64'(busy), 64'd0);
    tick();
    csr_rdv = '0;
    chk("late_v_ignored", 64'(rdv), 64'd0);
    chk("late_cnt", 64'(tcnt), 64'd1);

    // Read and write to non-existent channel 5
    rd_en = 1'b1; addr = {8'd5, 14'h0001};
    tick();
    rd_en = 1'b0;
    chk("bad_rd_nostrobe", 64'(csr_rd), 64'h0);
    chk("bad_rd_busy", 64'(busy), 64'd1);
    tick();
    chk("bad_rd_v", 64'(rdv), 64'd1);
    chk("bad_rd_err", 64'(rderr), 64'd1);
    chk("bad_rd_data", rdata, ToData);
    chk("bad_rd_cnt", 64'(tcnt), 64'd1);
    tick();
    chk("bad_rd_done", 64'({busy, rdv}), 64'd0);
    wr_en = 1'b1; addr = {8'd5, 14'h3FFF}; wdata = 64'hAAAA;
    tick();
    wr_en = 1'b0;
    chk("bad_wr_nostrobe", 64'(csr_wr), 64'h0);
    tick();
    chk("bad_wr_done", 64'({busy, rdv}), 64'd0);
    chk("bad_wr_wdata", csr_wdata[63:0], 64'hAAAA);

    // Simultaneous rd+wr on ch0, writes while busy, valid on the expiry cycle
    rd_en = 1'b1; wr_en = 1'b1; addr = {8'd0, 14'h0005}; wdata = 64'h5A5A;
    tick();
    rd_en = 1'b0; addr = {8'd1, 14'h0006};
    chk("both_rd", 64'(csr_rd), 64'h1);
    chk("both_no_wr", 64'(csr_wr), 64'h0);
    chk("both_wdata_kept", csr_wdata[63:0], 64'hAAAA);
    tick();
    chk("busy_wr_a", 64'({csr_wr, csr_rd}), 64'h0);
    tick();
    wr_en = 1'b0;
    chk("busy_wr_b", 64'({csr_wr, csr_rd}), 64'h0);
    tick(6);
    chk("exp_pre_v", 64'(rdv), 64'd0);
    csr_rdv[0] = 1'b1; csr_rdata[63:0] = 64'h77;
    tick();
    csr_rdv = '0;
    chk("exp_v", 64'(rdv), 64'd1);
    chk("exp_err", 64'(rderr), 64'd0);
    chk("exp_data", rdata, 64'h77);
    chk("exp_cnt", 64'(tcnt), 64'd1);
    tick();
    chk("exp_busy_off", 64'(busy), 64'd0);

    // Reset asserted while waiting on channel 2
    rd_en = 1'b1; addr = {8'd2, 14'h0002};
    tick();
    rd_en = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_strobes", 64'({csr_wr, csr_rd}), 64'd0);
    chk("mrst_rd", 64'({rdv, rderr}), 64'd0);
    chk("mrst_rdata", rdata, 64'd0);
    chk("mrst_addr", 64'(csr_addr), 64'd0);
    chk("mrst_wdata", csr_wdata[63:0], 64'd0);
    chk("mrst_tcnt", 64'(tcnt), 64'd0);
    tick(2);
    rst_n = 1'b1;
    csr_rdv[2] = 1'b1; csr_rdata[191:128] = 64'h99;
    for (int i = 0; i < 12; i++) begin
      tick();
      csr_rdv = '0;
      chk("mrst_no_cpl", 64'({rdv, busy, csr_rd}), 64'd0);
    end

    // Saturation of the timeout counter, preloaded near the top
    force dut.timeout_cnt_q = 16'hFFFE;
    #1;
    release dut.timeout_cnt_q;
    for (int k = 0; k < 2; k++) begin
      rd_en = 1'b1; addr = {8'd3, 14'h0000};
      tick();
      rd_en = 1'b0;
      tick(9);
      chk("sat_v", 64'({rdv, rderr}), 64'h3);
      chk("sat_cnt", 64'(tcnt), 64'hFFFF);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fc1_kr_csr_bridge.md
# fc1_kr_csr_bridge

Single-host CSR bridge that shares one core-side register port among the CHANNELS per-channel FC1 KR PCS instances of the FC1 KR wrapper. It decodes a channel index from the host address, issues a one-cycle write or read strobe to that channel's CSR port, waits for read data with a timeout, and returns data or an error to the host. It sits in the core clock domain between the link register decoder and the wrapper's per-channel CSR inputs.

## Interface
- CHANNELS, 1, number of downstream channel CSR ports (1..256)
- TIMEOUT, 255, cycles to wait for iCSR_RD_DATA_V after a read strobe (1..65535)
- TIMEOUT_DATA, 64'hDEAD_BEEF_DEAD_BEEF, read data returned on timeout/decode error
- iCLK_CORE  in  1  core clock; all logic on rising edge
- iRST_CORE_N  in  1  asynchronous active-low reset
- iHOST_WR_EN  in  1  host write request (sampled only when oHOST_BUSY=0)
- iHOST_RD_EN  in  1  host read request (sampled only when oHOST_BUSY=0)
- iHOST_ADDR  in  22  [21:14] channel index, [13:0] channel-local address
- iHOST_WR_DATA  in  64  write data
- oHOST_BUSY  out  1  request in flight; new requests ignored
- oHOST_RD_DATA  out  64  read return data, valid with oHOST_RD_DATA_V
- oHOST_RD_DATA_V  out  1  one-cycle read completion pulse
- oHOST_RD_ERR  out  1  qualifies oHOST_RD_DATA_V: timeout or bad channel
- oCSR_WR_EN  out  CHANNELS  one-hot write strobe
- oCSR_RD_EN  out  CHANNELS  one-hot read strobe
- oCSR_ADDR  out  CHANNELS x 14  local address, broadcast to all channels
- oCSR_WR_DATA  out  CHANNELS x 64  write data, broadcast to all channels
- iCSR_RD_DATA  in  CHANNELS x 64  per-channel read data
- iCSR_RD_DATA_V  in  CHANNELS  per-channel read data valid
- oTIMEOUT_CNT  out  16  saturating count of read timeouts

## Operation
- States: IDLE, ISSUE, RD_WAIT, RESP.
- IDLE: oHOST_BUSY=0. iHOST_RD_EN=1 → capture addr/ch, go ISSUE (read). Else iHOST_WR_EN=1 → capture addr/data/ch, go ISSUE (write). Both set: read wins, write dropped.
- ISSUE (1 cycle): if ch < CHANNELS, strobe oCSR_WR_EN[ch] or oCSR_RD_EN[ch]; write → IDLE, read → RD_WAIT with wait counter cleared. If ch >= CHANNELS: no strobe; write → IDLE (dropped); read → RESP with error.
- RD_WAIT: wait counter increments each cycle. iCSR_RD_DATA_V[ch]=1 → latch iCSR_RD_DATA[ch], go RESP, no error. Counter reaches TIMEOUT with no valid → go RESP with error, oTIMEOUT_CNT+1 (saturates at 16'hFFFF). Valid and expiry in same cycle: valid wins, no error.
- RESP (1 cycle): oHOST_RD_DATA_V=1, oHOST_RD_DATA = latched data or TIMEOUT_DATA, oHOST_RD_ERR=1 on error; → IDLE.
- iCSR_RD_DATA_V from a non-selected channel, or in any state other than RD_WAIT, is ignored. A late valid after timeout is discarded.
- oCSR_ADDR/oCSR_WR_DATA are registered, update at capture, hold until next capture.
- Host requests in non-IDLE states are ignored (no queueing).

## Timing
- Reset (async assert, sync release): state IDLE, all strobes 0, oHOST_BUSY=0, oHOST_RD_DATA=0, oHOST_RD_DATA_V=0, oHOST_RD_ERR=0, oCSR_ADDR=0, oCSR_WR_DATA=0, oTIMEOUT_CNT=0, wait counter 0.
- Request accepted in cycle T; oHOST_BUSY=1 from T+1 until state returns to IDLE.
- Write: strobe at T+1; oHOST_BUSY=0 at T+2; max one write per 2 cycles.
- Read: strobe at T+1; valid sampled at cycle R ≥ T+2 → oHOST_RD_DATA_V at R+1; oHOST_BUSY=0 at R+2. Zero-latency channel (valid at T+2) gives completion at T+3.
- Timeout: expiry at T+1+TIMEOUT → completion pulse at T+2+TIMEOUT.
- Bad-channel read: error completion at T+2.
- All outputs registered; no combinational path from host inputs to any output.
- Reset mid-transaction aborts it; no strobe or completion emitted afterward.

## Test plan
- CHANNELS=4: write addr {8'd2,14'h0010}, data 64'h1234 → oCSR_WR_EN=4'b0100 at T+1 for one cycle, oCSR_ADDR=14'h0010, oCSR_WR_DATA=64'h1234; busy low at T+2.
- Read ch1, model returns valid 3 cycles after strobe with 64'hCAFE → oHOST_RD_DATA_V one cycle, data 64'hCAFE, err=0; ch0/ch2 strobes stay 0.
- TIMEOUT=8, ch3 never responds → completion at T+10, data 64'hDEAD_BEEF_DEAD_BEEF, err=1, oTIMEOUT_CNT=1; late valid afterward ignored.
- Read ch5 with CHANNELS=4 → no strobes, error completion at T+2; write ch5 → no strobes, no completion.
- Simultaneous rd+wr on ch0 → only oCSR_RD_EN[0] pulses; requests during busy produce no strobes; valid on expiry cycle → err=0.
- Assert iRST_CORE_N low during RD_WAIT → all outputs 0 immediately; no completion after release; force 65536 timeouts → oTIMEOUT_CNT holds 16'hFFFF.
